// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU, loader), the arbiter and the memory array.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  i_CPU_Req;
  logic                  i_CPU_WE;
  logic [ADDR_WIDTH-1:0] i_CPU_Addr;
  logic [DATA_WIDTH-1:0] i_CPU_Data;
  logic [DATA_WIDTH-1:0] o_CPU_Data;
  logic                  o_CPU_Ready;
  logic                  i_LD_Req;
  logic                  i_LD_WE;
  logic [ADDR_WIDTH-1:0] i_LD_Addr;
  logic [DATA_WIDTH-1:0] i_LD_Data;
  logic [DATA_WIDTH-1:0] o_LD_Data;
  logic                  o_LD_Ready;
  logic [ADDR_WIDTH-1:0] o_Mem_Addr;
  logic                  o_Mem_WE;
  logic [DATA_WIDTH-1:0] o_Mem_Data;
  logic [DATA_WIDTH-1:0] i_Mem_Data;
  logic                  o_Busy;

  modport slave (
    input  i_CPU_Req, i_CPU_WE, i_CPU_Addr, i_CPU_Data,
    output o_CPU_Data, o_CPU_Ready,
    input  i_LD_Req, i_LD_WE, i_LD_Addr, i_LD_Data,
    output o_LD_Data, o_LD_Ready,
    output o_Mem_Addr, o_Mem_WE, o_Mem_Data,
    input  i_Mem_Data,
    output o_Busy
  );

  modport master (
    output i_CPU_Req, i_CPU_WE, i_CPU_Addr, i_CPU_Data,
    input  o_CPU_Data, o_CPU_Ready,
    output i_LD_Req, i_LD_WE, i_LD_Addr, i_LD_Data,
    input  o_LD_Data, o_LD_Ready,
    input  o_Mem_Addr, o_Mem_WE, o_Mem_Data,
    output i_Mem_Data,
    input  o_Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// LC-3 main-memory arbiter: wait-state FSM sharing one memory between the CPU and loader ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input logic          i_CLK,
  input logic          i_Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic       we_lat;
  logic       grant_ld;
  logic       pick_ld;

`ifdef MEM_ARB_RR_EN
  logic last_ld;

  // Tie goes to whichever port was not granted last; a lone request always wins.
  always_comb begin
    pick_ld = bus.i_LD_Req && (!bus.i_CPU_Req || !last_ld);
  end
`else
  always_comb begin
    pick_ld = bus.i_LD_Req && !bus.i_CPU_Req;
  end
`endif

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      state           <= IDLE;
      cnt             <= '0;
      we_lat          <= 1'b0;
      grant_ld        <= 1'b0;
      bus.o_CPU_Data  <= '0;
      bus.o_CPU_Ready <= 1'b0;
      bus.o_LD_Data   <= '0;
      bus.o_LD_Ready  <= 1'b0;
      bus.o_Mem_Addr  <= '0;
      bus.o_Mem_WE    <= 1'b0;
      bus.o_Mem_Data  <= '0;
      bus.o_Busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ld         <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_CPU_Req || bus.i_LD_Req) begin
            grant_ld       <= pick_ld;
            we_lat         <= pick_ld ? bus.i_LD_WE   : bus.i_CPU_WE;
            bus.o_Mem_Addr <= pick_ld ? bus.i_LD_Addr : bus.i_CPU_Addr;
            bus.o_Mem_Data <= pick_ld ? bus.i_LD_Data : bus.i_CPU_Data;
            cnt            <= CNT_INIT;
            bus.o_Busy     <= 1'b1;
            state          <= ACCESS;
`ifdef MEM_ARB_RR_EN
            last_ld        <= pick_ld;
`endif
          end
        end

        ACCESS: begin
          // Strobe is registered one cycle early so it is high exactly in the count==0 cycle.
          if (cnt == 4'd1) begin
            bus.o_Mem_WE <= we_lat;
          end
          if (cnt == 4'd0) begin
            bus.o_Mem_WE <= 1'b0;
            if (!we_lat) begin
              if (grant_ld) bus.o_LD_Data  <= bus.i_Mem_Data;
              else          bus.o_CPU_Data <= bus.i_Mem_Data;
            end
            bus.o_LD_Ready  <= grant_ld;
            bus.o_CPU_Ready <= !grant_ld;
            state           <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          bus.o_CPU_Ready <= 1'b0;
          bus.o_LD_Ready  <= 1'b0;
          bus.o_Busy      <= 1'b0;
          state           <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: dut0 at WAIT_STATES=2, dut1 at WAIT_STATES=1, each with a
// synchronous-read memory model. Expected arbitration follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus1 ();

  mem_arbiter #(.WAIT_STATES(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut0 (
    .i_CLK(clk), .i_Reset(rst), .bus(bus0)
  );
  mem_arbiter #(.WAIT_STATES(1), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut1 (
    .i_CLK(clk), .i_Reset(rst), .bus(bus1)
  );

  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic [15:0] rd0, rd1;
  logic        pre_en0 = 1'b0, pre_en1 = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;

  always @(posedge clk) begin
    if (pre_en0) mem0[pre_addr] <= pre_data;
    else if (bus0.o_Mem_WE) mem0[bus0.o_Mem_Addr] <= bus0.o_Mem_Data;
    rd0 <= mem0[bus0.o_Mem_Addr];
  end
  always @(posedge clk) begin
    if (pre_en1) mem1[pre_addr] <= pre_data;
    else if (bus1.o_Mem_WE) mem1[bus1.o_Mem_Addr] <= bus1.o_Mem_Data;
    rd1 <= mem1[bus1.o_Mem_Addr];
  end
  assign bus0.i_Mem_Data = rd0;
  assign bus1.i_Mem_Data = rd1;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations of dut0, filled by observe0
  int          cpu_cycs[$];
  int          ld_cycs[$];
  int          we_cnt;
  int          we_cyc;
  logic [15:0] we_addr;
  logic [15:0] we_data;
  logic [15:0] busy_log;

  task automatic preload(input bit which, input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    if (which) pre_en1 = 1'b1; else pre_en0 = 1'b1;
    @(negedge clk);
    pre_en0 = 1'b0;
    pre_en1 = 1'b0;
  endtask

  // Steps ncyc cycles from the current negedge (cycle 0) recording dut0 activity;
  // with drop set, each requester releases its request on seeing its ready pulse.
  task automatic observe0(input int ncyc, input bit drop);
    cpu_cycs.delete();
    ld_cycs.delete();
    we_cnt   = 0;
    we_cyc   = -1;
    we_addr  = '0;
    we_data  = '0;
    busy_log = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_log[c] = bus0.o_Busy;
      if (bus0.o_CPU_Ready) begin
        cpu_cycs.push_back(c);
        if (drop) bus0.i_CPU_Req = 1'b0;
      end
      if (bus0.o_LD_Ready) begin
        ld_cycs.push_back(c);
        if (drop) bus0.i_LD_Req = 1'b0;
      end
      if (bus0.o_Mem_WE) begin
        we_cnt++;
        we_cyc  = c;
        we_addr = bus0.o_Mem_Addr;
        we_data = bus0.o_Mem_Data;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus0.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus0.o_Busy); end
    n_checks++; if (bus0.o_CPU_Ready !== 1'b0 || bus0.o_LD_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got cpu=%b ld=%b expected 0/0", bus0.o_CPU_Ready, bus0.o_LD_Ready); end
    n_checks++; if (bus0.o_Mem_WE !== 1'b0 || bus0.o_Mem_Addr !== 16'h0 || bus0.o_Mem_Data !== 16'h0) begin n_fail++; $display("FAIL reset_mem_side: got we=%b addr=%h data=%h expected 0/0000/0000", bus0.o_Mem_WE, bus0.o_Mem_Addr, bus0.o_Mem_Data); end
    n_checks++; if (bus0.o_CPU_Data !== 16'h0 || bus0.o_LD_Data !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got cpu=%h ld=%h expected 0000/0000", bus0.o_CPU_Data, bus0.o_LD_Data); end
    n_checks++; if (bus1.o_Busy !== 1'b0 || bus1.o_CPU_Data !== 16'h0) begin n_fail++; $display("FAIL reset_dut1: got busy=%b data=%h expected 0/0000", bus1.o_Busy, bus1.o_CPU_Data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    preload(1'b0, 16'h3000, 16'h1234);
    bus0.i_CPU_WE   = 1'b0;
    bus0.i_CPU_Addr = 16'h3000;
    bus0.i_CPU_Req  = 1'b1;
    observe0(7, 1'b1);
    n_checks++; if (cpu_cycs.size() != 1 || cpu_cycs[0] != 4) begin n_fail++; $display("FAIL cpu_read_ready: got %0d pulses first at %0d expected 1 pulse at 4", cpu_cycs.size(), cpu_cycs[0]); end
    n_checks++; if (bus0.o_CPU_Data !== 16'h1234) begin n_fail++; $display("FAIL cpu_read_data: got %h expected 1234", bus0.o_CPU_Data); end
    n_checks++; if (ld_cycs.size() != 0) begin n_fail++; $display("FAIL cpu_read_ld_ready: got %0d pulses expected 0", ld_cycs.size()); end
    n_checks++; if (we_cnt != 0) begin n_fail++; $display("FAIL cpu_read_we: got %0d strobes expected 0", we_cnt); end
    n_checks++; if (busy_log !== 16'h001E) begin n_fail++; $display("FAIL cpu_read_busy: got %h expected 001e", busy_log); end
  endtask

  task automatic test_ld_write_cpu_read();
    bus0.i_LD_WE   = 1'b1;
    bus0.i_LD_Addr = 16'h0005;
    bus0.i_LD_Data = 16'hBEEF;
    bus0.i_LD_Req  = 1'b1;
    observe0(7, 1'b1);
    n_checks++; if (we_cnt != 1 || we_cyc != 3) begin n_fail++; $display("FAIL ld_write_we: got %0d strobes last at %0d expected 1 at 3", we_cnt, we_cyc); end
    n_checks++; if (we_addr !== 16'h0005 || we_data !== 16'hBEEF) begin n_fail++; $display("FAIL ld_write_bus: got addr=%h data=%h expected 0005/beef", we_addr, we_data); end
    n_checks++; if (ld_cycs.size() != 1 || ld_cycs[0] != 4 || cpu_cycs.size() != 0) begin n_fail++; $display("FAIL ld_write_ready: got ld=%0d first %0d cpu=%0d expected ld 1 at 4 cpu 0", ld_cycs.size(), ld_cycs[0], cpu_cycs.size()); end
    n_checks++; if (bus0.o_LD_Data !== 16'h0000 || bus0.o_CPU_Data !== 16'h1234) begin n_fail++; $display("FAIL ld_write_rdata_hold: got ld=%h cpu=%h expected 0000/1234", bus0.o_LD_Data, bus0.o_CPU_Data); end
    bus0.i_LD_WE    = 1'b0;
    bus0.i_CPU_WE   = 1'b0;
    bus0.i_CPU_Addr = 16'h0005;
    bus0.i_CPU_Req  = 1'b1;
    observe0(7, 1'b1);
    n_checks++; if (cpu_cycs.size() != 1 || cpu_cycs[0] != 4) begin n_fail++; $display("FAIL cpu_readback_ready: got %0d pulses first at %0d expected 1 at 4", cpu_cycs.size(), cpu_cycs[0]); end
    n_checks++; if (bus0.o_CPU_Data !== 16'hBEEF) begin n_fail++; $display("FAIL cpu_readback_data: got %h expected beef", bus0.o_CPU_Data); end
  endtask

  task automatic test_simultaneous();
    preload(1'b0, 16'h0010, 16'h1010);
    preload(1'b0, 16'h0020, 16'h2020);
    bus0.i_CPU_WE   = 1'b0;
    bus0.i_CPU_Addr = 16'h0010;
    bus0.i_LD_WE    = 1'b0;
    bus0.i_LD_Addr  = 16'h0020;
    bus0.i_CPU_Req  = 1'b1;
    bus0.i_LD_Req   = 1'b1;
    observe0(15, 1'b0);
    bus0.i_CPU_Req = 1'b0;
    bus0.i_LD_Req  = 1'b0;
`ifdef MEM_ARB_RR_EN
    n_checks++; if (cpu_cycs.size() != 2 || cpu_cycs[0] != 4 || cpu_cycs[1] != 14) begin n_fail++; $display("FAIL rr_cpu_grants: got %0d pulses at %0d,%0d expected 2 at 4,14", cpu_cycs.size(), cpu_cycs[0], cpu_cycs[1]); end
    n_checks++; if (ld_cycs.size() != 1 || ld_cycs[0] != 9) begin n_fail++; $display("FAIL rr_ld_grants: got %0d pulses first at %0d expected 1 at 9", ld_cycs.size(), ld_cycs[0]); end
    n_checks++; if (bus0.o_LD_Data !== 16'h2020) begin n_fail++; $display("FAIL rr_ld_data: got %h expected 2020", bus0.o_LD_Data); end
`else
    n_checks++; if (cpu_cycs.size() != 3 || cpu_cycs[0] != 4 || cpu_cycs[1] != 9 || cpu_cycs[2] != 14) begin n_fail++; $display("FAIL fixed_cpu_grants: got %0d pulses at %0d,%0d,%0d expected 3 at 4,9,14", cpu_cycs.size(), cpu_cycs[0], cpu_cycs[1], cpu_cycs[2]); end
    n_checks++; if (ld_cycs.size() != 0) begin n_fail++; $display("FAIL fixed_ld_starved: got %0d pulses expected 0", ld_cycs.size()); end
    n_checks++; if (bus0.o_LD_Data !== 16'h0000) begin n_fail++; $display("FAIL fixed_ld_data: got %h expected 0000", bus0.o_LD_Data); end
`endif
    n_checks++; if (bus0.o_CPU_Data !== 16'h1010) begin n_fail++; $display("FAIL simul_cpu_data: got %h expected 1010", bus0.o_CPU_Data); end
    repeat (6) @(negedge clk);
    n_checks++; if (bus0.o_Busy !== 1'b0) begin n_fail++; $display("FAIL simul_settle_busy: got %b expected 0", bus0.o_Busy); end
  endtask

  task automatic test_reset_mid_access();
    preload(1'b0, 16'h0040, 16'h1111);
    bus0.i_CPU_WE   = 1'b1;
    bus0.i_CPU_Addr = 16'h0040;
    bus0.i_CPU_Data = 16'h5555;
    bus0.i_CPU_Req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst            = 1'b1;
    bus0.i_CPU_Req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus0.o_Mem_WE !== 1'b0 || bus0.o_Busy !== 1'b0 || bus0.o_CPU_Ready !== 1'b0 || bus0.o_LD_Ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got we=%b busy=%b rdy=%b/%b expected all 0", bus0.o_Mem_WE, bus0.o_Busy, bus0.o_CPU_Ready, bus0.o_LD_Ready); end
    n_checks++; if (bus0.o_Mem_Addr !== 16'h0 || bus0.o_Mem_Data !== 16'h0 || bus0.o_CPU_Data !== 16'h0 || bus0.o_LD_Data !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got addr=%h wdata=%h cpu=%h ld=%h expected all 0000", bus0.o_Mem_Addr, bus0.o_Mem_Data, bus0.o_CPU_Data, bus0.o_LD_Data); end
    rst = 1'b0;
    observe0(6, 1'b1);
    n_checks++; if (we_cnt != 0 || cpu_cycs.size() != 0 || busy_log !== 16'h0) begin n_fail++; $display("FAIL midrst_no_retry: got we=%0d ready=%0d busy=%h expected 0/0/0000", we_cnt, cpu_cycs.size(), busy_log); end
    n_checks++; if (mem0[16'h0040] !== 16'h1111) begin n_fail++; $display("FAIL midrst_mem_word: got %h expected 1111", mem0[16'h0040]); end
  endtask

  task automatic test_reset_with_request();
    bus0.i_CPU_WE   = 1'b0;
    bus0.i_CPU_Addr = 16'h3000;
    bus0.i_CPU_Req  = 1'b1;
    rst             = 1'b1;
    @(negedge clk);
    bus0.i_CPU_Req = 1'b0;
    rst            = 1'b0;
    @(negedge clk);
    n_checks++; if (bus0.o_Busy !== 1'b0 || bus0.o_Mem_Addr !== 16'h0) begin n_fail++; $display("FAIL rst_req_no_grant: got busy=%b addr=%h expected 0/0000", bus0.o_Busy, bus0.o_Mem_Addr); end
  endtask

  task automatic test_ws1_boundary();
    int rdy_cnt;
    int rdy_cyc;
    preload(1'b1, 16'hFFFF, 16'hA5C3);
    rdy_cnt = 0;
    rdy_cyc = -1;
    bus1.i_CPU_WE   = 1'b0;
    bus1.i_CPU_Addr = 16'hFFFF;
    bus1.i_CPU_Req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (bus1.o_Mem_Addr !== 16'hFFFF || bus1.o_Busy !== 1'b1) begin n_fail++; $display("FAIL ws1_access: got addr=%h busy=%b expected ffff/1", bus1.o_Mem_Addr, bus1.o_Busy); end
      end
      if (c == 2) bus1.i_CPU_Req = 1'b0;
      if (bus1.o_CPU_Ready) begin
        rdy_cnt++;
        if (rdy_cyc < 0) rdy_cyc = c;
      end
    end
    n_checks++; if (rdy_cnt != 1 || rdy_cyc != 3) begin n_fail++; $display("FAIL ws1_ready: got %0d pulses first at %0d expected 1 at 3", rdy_cnt, rdy_cyc); end
    n_checks++; if (bus1.o_CPU_Data !== 16'hA5C3) begin n_fail++; $display("FAIL ws1_data: got %h expected a5c3", bus1.o_CPU_Data); end
    n_checks++; if (bus1.o_Busy !== 1'b0 || bus1.o_LD_Ready !== 1'b0) begin n_fail++; $display("FAIL ws1_idle: got busy=%b ld_rdy=%b expected 0/0", bus1.o_Busy, bus1.o_LD_Ready); end
  endtask

  initial begin
    bus0.i_CPU_Req = 1'b0; bus0.i_CPU_WE = 1'b0; bus0.i_CPU_Addr = '0; bus0.i_CPU_Data = '0;
    bus0.i_LD_Req  = 1'b0; bus0.i_LD_WE  = 1'b0; bus0.i_LD_Addr  = '0; bus0.i_LD_Data  = '0;
    bus1.i_CPU_Req = 1'b0; bus1.i_CPU_WE = 1'b0; bus1.i_CPU_Addr = '0; bus1.i_CPU_Data = '0;
    bus1.i_LD_Req  = 1'b0; bus1.i_LD_WE  = 1'b0; bus1.i_LD_Addr  = '0; bus1.i_LD_Data  = '0;
    test_reset();
    test_cpu_read();
    test_ld_write_cpu_read();
    test_simultaneous();
    test_reset_mid_access();
    test_reset_with_request();
    test_ws1_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
